// File: rtl/code_lock_pkg.sv
// Shared types, glyphs and helpers for the code lock.
package code_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_SET,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKOUT
  } state_e;

  // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] GLYPH_O     = 8'hC0;
  localparam logic [7:0] GLYPH_E     = 8'h86;
  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return GLYPH_BLANK;
    endcase
  endfunction

  // Decimal digit increment, 9 wraps to 0
  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/code_lock_if.sv
// Board-side signal bundle of the code lock: raw controls in, display/flags out.
interface code_lock_if #(
  parameter int DIGITS = 4
);
  logic              btn_inc;
  logic              btn_next;
  logic              btn_enter;
  logic              sw_set;
  logic [DIGITS-1:0] an;
  logic [7:0]        seg;
  logic              unlocked;
  logic              alarm;

  modport master (output btn_inc, btn_next, btn_enter, sw_set,
                  input  an, seg, unlocked, alarm);
  modport slave  (input  btn_inc, btn_next, btn_enter, sw_set,
                  output an, seg, unlocked, alarm);
endinterface

// File: rtl/code_lock_key_debounce.sv
// Button synchroniser + debouncer producing one pulse per accepted press.
// The accepted level resets to "pressed" so a button held through reset
// release must first be seen released before a new press can pulse.
module key_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Synchroniser and debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  // Accept a new level after DEB_CYC consecutive differing samples
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DW'(DEB_CYC - 1)) begin
        stable_d = sync2_q;
        pulse_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/code_lock.sv
// Digit-entry code lock with set mode, retry lockout and multiplexed display.
module code_lock
  import code_lock_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_CYC = 500_000_000,
  parameter int DEB_CYC     = 1_000_000,
  parameter int SCAN_CYC    = 20_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_inc,
  input  logic              btn_next,
  input  logic              btn_enter,
  input  logic              sw_set,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg,
  output logic              unlocked,
  output logic              alarm
);
  localparam int CW = $clog2(DIGITS);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int LW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam int SW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

  logic inc_p, next_p, enter_p;
  logic sw_meta_q, sw_q;

  state_e                 state_q, state_d;
  logic [DIGITS-1:0][3:0] entry_q, entry_d, code_q, code_d, edit_buf;
  logic [CW-1:0]          cursor_q, cursor_d, edit_cur;
  logic [FW-1:0]          fail_q, fail_d, fail_inc;
  logic [LW-1:0]          lock_q, lock_d;
  logic [SW-1:0]          scan_q, scan_d;
  logic [CW-1:0]          slot_q, slot_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic [7:0]             seg_q, seg_d;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc   (.clk(clk), .rst_n(rst_n), .raw(btn_inc),   .pulse(inc_p));
  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_next  (.clk(clk), .rst_n(rst_n), .raw(btn_next),  .pulse(next_p));
  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_enter (.clk(clk), .rst_n(rst_n), .raw(btn_enter), .pulse(enter_p));

  // Two-flop synchroniser for the set-mode switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= 1'b0;
      sw_q      <= 1'b0;
    end else begin
      sw_meta_q <= sw_set;
      sw_q      <= sw_meta_q;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ENTRY;
      entry_q  <= '0;
      code_q   <= '0;
      cursor_q <= '0;
      fail_q   <= '0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      code_q   <= code_d;
      cursor_q <= cursor_d;
      fail_q   <= fail_d;
      lock_q   <= lock_d;
    end
  end

  // Shared editor: inc applies to the cursor digit before next moves it
  always_comb begin
    edit_buf = (state_q == ST_SET) ? code_q : entry_q;
    edit_cur = cursor_q;
    if (inc_p)
      edit_buf[cursor_q] = digit_inc(edit_buf[cursor_q]);
    if (next_p)
      edit_cur = (cursor_q == CW'(DIGITS - 1)) ? '0 : cursor_q + CW'(1);
  end

  // Next-state logic; enter always wins over inc/next
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    code_d   = code_q;
    cursor_d = cursor_q;
    fail_d   = fail_q;
    lock_d   = lock_q;
    fail_inc = fail_q + FW'(1);
    case (state_q)
      ST_ENTRY: begin
        if (enter_p) begin
          if (entry_q == code_q) begin
            state_d = ST_OPEN;
            fail_d  = '0;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == FW'(MAX_TRIES)) begin
              state_d = ST_LOCKOUT;
              lock_d  = LW'(LOCKOUT_CYC - 1);
            end else begin
              state_d = ST_FAIL;
            end
          end
        end else begin
          entry_d  = edit_buf;
          cursor_d = edit_cur;
        end
      end
      ST_SET: begin
        if (!sw_q) begin
          state_d = ST_OPEN;
        end else if (!enter_p) begin
          code_d   = edit_buf;
          cursor_d = edit_cur;
        end
      end
      ST_OPEN: begin
        if (enter_p) begin
          state_d  = ST_ENTRY;
          entry_d  = '0;
          cursor_d = '0;
        end else if (sw_q) begin
          state_d  = ST_SET;
          cursor_d = '0;
        end
      end
      ST_FAIL: begin
        if (enter_p) begin
          state_d  = ST_ENTRY;
          entry_d  = '0;
          cursor_d = '0;
        end
      end
      ST_LOCKOUT: begin
        if (lock_q == '0) begin
          state_d  = ST_ENTRY;
          fail_d   = '0;
          entry_d  = '0;
          cursor_d = '0;
        end else begin
          lock_d = lock_q - LW'(1);
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // Display scan: SCAN_CYC cycles per slot, slots wrap at DIGITS
  always_comb begin
    scan_d = scan_q + SW'(1);
    slot_d = slot_q;
    if (scan_q == SW'(SCAN_CYC - 1)) begin
      scan_d = '0;
      slot_d = (slot_q == CW'(DIGITS - 1)) ? '0 : slot_q + CW'(1);
    end
  end

  // Outputs: status flags and the pattern for the current slot
  always_comb begin
    unlocked = (state_q == ST_OPEN) || (state_q == ST_SET);
    alarm    = (state_q == ST_LOCKOUT);
    an_d     = '1;
    an_d[slot_q] = 1'b0;
    case (state_q)
      ST_ENTRY:   seg_d = bcd_to_seg(entry_q[slot_q]);
      ST_SET:     seg_d = bcd_to_seg(code_q[slot_q]);
      ST_OPEN:    seg_d = GLYPH_O;
      ST_FAIL:    seg_d = GLYPH_E;
      ST_LOCKOUT: seg_d = GLYPH_DASH;
      default:    seg_d = GLYPH_BLANK;
    endcase
    if (((state_q == ST_ENTRY) || (state_q == ST_SET)) && (slot_q == cursor_q))
      seg_d[7] = 1'b0;
  end

  // Display registers; an and seg move together so they stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      slot_q <= '0;
      an_q   <= ~DIGITS'(1);
      seg_q  <= GLYPH_BLANK;
    end else begin
      scan_q <= scan_d;
      slot_q <= slot_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_code_lock.sv
module tb_code_lock;
  localparam int DIGITS      = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCKOUT_CYC = 100;
  localparam int DEB_CYC     = 4;
  localparam int SCAN_CYC    = 8;

  // Active-low patterns {dp,g..a}; Dn = digit n with dp lit
  localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0;
  localparam logic [7:0] D0 = 8'h40, D1 = 8'h79, D2 = 8'h24;
  localparam logic [7:0] GO = 8'hC0, GE = 8'h86, GD = 8'hBF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  code_lock_if #(.DIGITS(DIGITS)) bus ();

  code_lock #(
    .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYC(LOCKOUT_CYC),
    .DEB_CYC(DEB_CYC), .SCAN_CYC(SCAN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_inc(bus.btn_inc), .btn_next(bus.btn_next), .btn_enter(bus.btn_enter),
    .sw_set(bus.sw_set), .an(bus.an), .seg(bus.seg),
    .unlocked(bus.unlocked), .alarm(bus.alarm)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string                 name;
    logic                  sw;
    logic [2:0]            btn;   // {enter,next,inc}
    logic [DIGITS-1:0][7:0] seg;  // digit3..digit0
    logic                  unl;
    logic                  alm;
  } vec_t;

  vec_t vt [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] m);
    bus.btn_inc   = m[0];
    bus.btn_next  = m[1];
    bus.btn_enter = m[2];
    cyc(12);
    bus.btn_inc   = 1'b0;
    bus.btn_next  = 1'b0;
    bus.btn_enter = 1'b0;
    cyc(12);
  endtask

  task automatic check_disp(input string name, input logic [DIGITS-1:0][7:0] exp);
    logic [DIGITS-1:0][7:0] got;
    logic [DIGITS-1:0]      seen;
    int                     bad;
    got  = 'x;
    seen = '0;
    bad  = 0;
    for (int k = 0; k < DIGITS * SCAN_CYC + 2; k++) begin
      @(negedge clk);
      if ($countones(~bus.an) != 1) bad++;
      else
        for (int i = 0; i < DIGITS; i++)
          if (!bus.an[i]) begin
            got[i]  = bus.seg;
            seen[i] = 1'b1;
          end
    end
    check({name, "_an_onehot"}, bad, 0);
    check({name, "_an_slots"}, seen, 4'hF);
    for (int i = 0; i < DIGITS; i++)
      check($sformatf("%s_seg%0d", name, i), got[i], exp[i]);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;

    vt[0]  = '{"idle",      1'b0, 3'b000, {S0, S0, S0, D0}, 1'b0, 1'b0};
    vt[1]  = '{"open0",     1'b0, 3'b100, {GO, GO, GO, GO}, 1'b1, 1'b0};
    vt[2]  = '{"set_enter", 1'b1, 3'b000, {S0, S0, S0, D0}, 1'b1, 1'b0};
    vt[3]  = '{"set_inc1",  1'b1, 3'b001, {S0, S0, S0, D1}, 1'b1, 1'b0};
    vt[4]  = '{"set_inc2",  1'b1, 3'b001, {S0, S0, S0, D2}, 1'b1, 1'b0};
    vt[5]  = '{"set_inc3",  1'b1, 3'b001, {S0, S0, S0, 8'h30}, 1'b1, 1'b0};
    vt[6]  = '{"set_next",  1'b1, 3'b010, {S0, S0, D0, S3}, 1'b1, 1'b0};
    vt[7]  = '{"set_inc4",  1'b1, 3'b001, {S0, S0, D1, S3}, 1'b1, 1'b0};
    vt[8]  = '{"set_inc5",  1'b1, 3'b001, {S0, S0, D2, S3}, 1'b1, 1'b0};
    vt[9]  = '{"set_exit",  1'b0, 3'b000, {GO, GO, GO, GO}, 1'b1, 1'b0};
    vt[10] = '{"relock",    1'b0, 3'b100, {S0, S0, S0, D0}, 1'b0, 1'b0};
    vt[11] = '{"ent_inc1",  1'b0, 3'b001, {S0, S0, S0, D1}, 1'b0, 1'b0};
    vt[12] = '{"ent_inc2",  1'b0, 3'b001, {S0, S0, S0, D2}, 1'b0, 1'b0};
    vt[13] = '{"ent_inc3",  1'b0, 3'b001, {S0, S0, S0, 8'h30}, 1'b0, 1'b0};
    vt[14] = '{"ent_next",  1'b0, 3'b010, {S0, S0, D0, S3}, 1'b0, 1'b0};
    vt[15] = '{"ent_inc4",  1'b0, 3'b001, {S0, S0, D1, S3}, 1'b0, 1'b0};
    vt[16] = '{"ent_inc5",  1'b0, 3'b001, {S0, S0, D2, S3}, 1'b0, 1'b0};
    vt[17] = '{"open0023",  1'b0, 3'b100, {GO, GO, GO, GO}, 1'b1, 1'b0};
    vt[18] = '{"close",     1'b0, 3'b100, {S0, S0, S0, D0}, 1'b0, 1'b0};
    vt[19] = '{"all3",      1'b0, 3'b111, {GE, GE, GE, GE}, 1'b0, 1'b0};
    vt[20] = '{"fail_ack1", 1'b0, 3'b100, {S0, S0, S0, D0}, 1'b0, 1'b0};
    vt[21] = '{"wrong2",    1'b0, 3'b100, {GE, GE, GE, GE}, 1'b0, 1'b0};
    vt[22] = '{"fail_ack2", 1'b0, 3'b100, {S0, S0, S0, D0}, 1'b0, 1'b0};

    // Reset values
    rst_n = 1'b0;
    bus.btn_inc = 1'b0; bus.btn_next = 1'b0; bus.btn_enter = 1'b0; bus.sw_set = 1'b0;
    cyc(2);
    check("rst_an", bus.an, 4'b1110);
    check("rst_seg", bus.seg, 8'hFF);
    check("rst_unlocked", bus.unlocked, 1'b0);
    check("rst_alarm", bus.alarm, 1'b0);
    rst_n = 1'b1;
    cyc(10);

    // Table-driven main sequence
    for (int i = 0; i < 23; i++) begin
      bus.sw_set = vt[i].sw;
      cyc(4);
      if (vt[i].btn != 3'b000) press(vt[i].btn);
      check_disp(vt[i].name, vt[i].seg);
      check({vt[i].name, "_unlocked"}, bus.unlocked, vt[i].unl);
      check({vt[i].name, "_alarm"}, bus.alarm, vt[i].alm);
    end

    // Digit wrap, cursor wrap, bounce rejection
    for (int i = 0; i < 11; i++) press(3'b001);
    for (int i = 0; i < 5; i++) press(3'b010);
    check_disp("wrap", {S0, S0, D0, S1});
    bus.btn_inc = 1'b1;
    cyc(2);
    bus.btn_inc = 1'b0;
    cyc(12);
    check_disp("glitch", {S0, S0, D0, S1});

    // Third wrong entry: lockout for exactly LOCKOUT_CYC cycles
    bus.btn_enter = 1'b1;
    w = 0;
    while (!bus.alarm && w < 40) begin cyc(1); w++; end
    check("lock_enter", bus.alarm, 1'b1);
    n = 0;
    while (bus.alarm && n < 300) begin
      if (n == 5)  bus.btn_enter = 1'b0;
      if (n == 10) bus.sw_set = 1'b1;
      if (n == 20) bus.btn_inc = 1'b1;
      if (n == 35) bus.btn_inc = 1'b0;
      if (n == 40) bus.btn_next = 1'b1;
      if (n == 55) bus.btn_next = 1'b0;
      if (n == 60) bus.sw_set = 1'b0;
      if (n == 50) check("lock_seg", bus.seg, GD);
      cyc(1);
      n++;
    end
    check("lock_len", n, LOCKOUT_CYC);
    check_disp("after_lock", {S0, S0, S0, D0});
    check("after_lock_alarm", bus.alarm, 1'b0);

    // Fail counter was cleared: two wrongs go to the error state only
    press(3'b100);
    check("refail1_seg", bus.seg, GE);
    check("refail1_alarm", bus.alarm, 1'b0);
    press(3'b100);
    press(3'b100);
    check("refail2_seg", bus.seg, GE);
    check("refail2_alarm", bus.alarm, 1'b0);
    press(3'b100);

    // Third wrong again, then reset mid-lockout with inc held through release
    bus.btn_enter = 1'b1;
    w = 0;
    while (!bus.alarm && w < 40) begin cyc(1); w++; end
    check("lock2_enter", bus.alarm, 1'b1);
    bus.btn_enter = 1'b0;
    cyc(50);
    bus.btn_inc = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_alarm", bus.alarm, 1'b0);
    check("midrst_an", bus.an, 4'b1110);
    check("midrst_seg", bus.seg, 8'hFF);
    check("midrst_unlocked", bus.unlocked, 1'b0);
    cyc(1);
    rst_n = 1'b1;
    cyc(20);
    bus.btn_inc = 1'b0;
    cyc(12);
    check_disp("held_inc", {S0, S0, S0, D0});
    press(3'b100);
    check("code_cleared_unlocked", bus.unlocked, 1'b1);
    check("code_cleared_seg", bus.seg, GO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/code_lock.md
CODE_LOCK -- requirements
Module: code_lock

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of decimal code digits and display positions (2..8).
REQ-002 The block SHALL have parameter MAX_TRIES, default 3, meaning consecutive wrong entries before lockout (1..15).
REQ-003 The block SHALL have parameter LOCKOUT_CYC, default 500_000_000, meaning lockout duration in clk cycles.
REQ-004 The block SHALL have parameter DEB_CYC, default 1_000_000, meaning the stable-input time for a debounced press, in clk cycles.
REQ-005 The block SHALL have parameter SCAN_CYC, default 20_000, meaning clk cycles per display digit slot.
REQ-006 The block SHALL have ports: clk in 1 system clock; rst_n in 1 async active-low reset; btn_inc in 1 raw increment button; btn_next in 1 raw cursor button; btn_enter in 1 raw enter button; sw_set in 1 set-mode switch; an out DIGITS active-low digit enables; seg out 8 active-low segments {dp,g..a}; unlocked out 1 open flag; alarm out 1 lockout flag.
REQ-007 There SHALL be one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-008 Each button SHALL be 2-flop synchronised, then accepted after DEB_CYC stable cycles; exactly one 1-cycle pulse per press (rising edge), none on release.
REQ-009 States SHALL be ENTRY, SET, OPEN, FAIL, LOCKOUT; reset state is ENTRY.
REQ-010 In ENTRY/SET, an inc pulse SHALL increment the cursor digit of the working buffer (entry buffer in ENTRY, stored code in SET) mod 10: 9 wraps to 0.
REQ-011 A next pulse SHALL advance the cursor mod DIGITS: DIGITS-1 wraps to 0.
REQ-012 Simultaneous inc and next SHALL increment the current digit, then advance the cursor, in the same cycle.
REQ-013 An enter pulse SHALL take priority over inc/next in the same cycle; inc/next in that cycle are discarded.
REQ-014 ENTRY + enter SHALL compare all DIGITS entry digits with the stored code; the result registers on the next clk edge (1-cycle latency).
REQ-015 On a match: go to OPEN; clear the fail counter; unlocked=1.
REQ-016 On a mismatch: increment the fail counter. If the count equals MAX_TRIES, go to LOCKOUT; else go to FAIL.
REQ-017 FAIL + enter SHALL return to ENTRY, clearing the entry buffer and cursor.
REQ-018 OPEN + enter SHALL return to ENTRY, clearing the buffer and cursor; unlocked=0.
REQ-019 OPEN with sw_set=1 SHALL go to SET (cursor 0). SET with sw_set=0 SHALL return to OPEN. sw_set SHALL be ignored in all other states.
REQ-020 LOCKOUT SHALL ignore all buttons and sw_set; alarm=1.
REQ-021 LOCKOUT SHALL load a counter with LOCKOUT_CYC-1 on entry and exit to ENTRY when it reaches 0, clearing the fail counter, entry buffer and cursor.
REQ-022 The display SHALL scan digit i for SCAN_CYC cycles, i = 0..DIGITS-1, wrapping.
REQ-023 Exactly one an bit SHALL be low at a time after reset.
REQ-024 Display content SHALL be: ENTRY = entry digits; SET = stored code; OPEN = glyph "O"; FAIL = glyph "E"; LOCKOUT = glyph "-", on every position.
REQ-025 dp SHALL be lit on the cursor digit in ENTRY/SET only.
REQ-026 All counters SHALL use $clog2-sized widths; digit values SHALL never exceed 9.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately set: state=ENTRY, entry buffer=0, stored code=0, cursor=0, fail counter=0, lockout counter=0, scan slot=0, an=all-ones except bit0 low, seg=8'hFF, unlocked=0, alarm=0.
REQ-028 Reset mid-lockout or mid-press SHALL abort the operation; a button still held at release of rst_n SHALL NOT generate a pulse.

Structure
REQ-029 A shared package code_lock_pkg SHALL hold the state enum, glyph constants (O, E, dash, blank) and the BCD-to-7-segment function.
REQ-030 One sub-module, key_debounce (parameter DEB_CYC; ports clk, rst_n, raw, pulse), SHALL be instantiated three times.

Verification (DIGITS=4, MAX_TRIES=3, LOCKOUT_CYC=100, DEB_CYC=4, SCAN_CYC=8)
REQ-031 Reset, then enter with the all-zero entry -> OPEN, unlocked=1, seg shows "O" on all 4 an slots.
REQ-032 OPEN, sw_set=1, inc x3, next, inc x2, sw_set=0, enter -> stored code 0,0,2,3 (digit3..0); entry of 0023 then gives unlocked=1.
REQ-033 inc x11 on digit0 -> value 1 (9->0 wrap); next x5 -> cursor 1; a 2-cycle bounce glitch -> no pulse.
REQ-034 Three wrong entries -> FAIL, FAIL, then LOCKOUT with alarm=1 for exactly 100 cycles; presses during lockout are ignored; then ENTRY with fail count 0.
REQ-035 rst_n low for 1 cycle at lockout count 50 -> alarm=0 immediately and the stored code returns to 0000.
REQ-036 inc, next and enter pulses in the same cycle while in ENTRY -> the compare executes and the digit and cursor are unchanged.
